// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// State encoding plus default requester count and byte width.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        START   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int UART_N  = 4;
    localparam int UART_DW = 8;

endpackage

// File: rtl/uart_done_sync.sv
// Two-flop synchronizer bringing the transmitter done level
// into the system clock domain.
module uart_done_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter between N requesters.
// UART_TX_ARB_RR_EN selects round-robin; otherwise fixed priority.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N  = UART_N,
    parameter int DW = UART_DW
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [N-1:0]    Req,
    input  logic [N*DW-1:0] Data,
    output logic [N-1:0]    Ack,
    output logic [N-1:0]    Grant,
    output logic          Busy,
    output logic          TxInit,
    output logic [DW-1:0]   TxData,
    input  logic          TxDone
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t        state;
    state_t        state_nx;
    logic          done_s;
    logic          found;
    logic [IW-1:0] pick;
    logic [IW-1:0] win;

    uart_done_sync u_sync (
        .clk (Clock),
        .rst (Reset),
        .d   (TxDone),
        .q   (done_s)
    );

`ifdef UART_TX_ARB_RR_EN
    logic [IW-1:0] ptr;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            ptr <= '0;
        else if (state == LOAD)
            ptr <= IW'((int'(win) + 1) % N);
    end
`endif

    // First set request, scanning from ptr (RR) or from index 0.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int j = 0; j < N; j++) begin
`ifdef UART_TX_ARB_RR_EN
            idx = (int'(ptr) + j) % N;
`else
            idx = j;
`endif
            if (!found && Req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found && !done_s) state_nx = LOAD;
            LOAD:    state_nx = START;
            START:   if (done_s) state_nx = RELEASE;
            RELEASE: if (!done_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            win <= '0;
        else if (state == IDLE && state_nx == LOAD)
            win <= pick;
    end

    // TxInit is only raised while done_s is low, so a stale done
    // at START entry never produces a start pulse.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Ack    <= '0;
            Grant  <= '0;
            Busy   <= 1'b0;
            TxInit <= 1'b0;
            TxData <= '0;
        end else begin
            Ack    <= '0;
            Busy   <= (state_nx != IDLE);
            TxInit <= (state == START) && !done_s;
            if (state == LOAD) begin
                TxData <= Data[int'(win)*DW +: DW];
                Grant  <= N'(1) << win;
                Ack    <= N'(1) << win;
            end else if (state == RELEASE && !done_s) begin
                Grant  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter with a 10-bit
// frame transmitter model; honours UART_TX_ARB_RR_EN.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int FRAME = 10;

    typedef struct {
        int         idx;
        logic [7:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic [N-1:0]    ack;
    logic [N-1:0]    grant;
    logic          busy;
    logic          txinit;
    logic [DW-1:0]   txdata;
    logic          txdone;

    logic          model_en;
    logic          tx_force;
    logic          mdone;
    int            mcnt;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_tx_arbiter #(.N(N), .DW(DW)) dut (
        .Clock  (clk),
        .Reset  (rst),
        .Req    (req),
        .Data   (data),
        .Ack    (ack),
        .Grant  (grant),
        .Busy   (busy),
        .TxInit (txinit),
        .TxData (txdata),
        .TxDone (txdone)
    );

    always #5 clk = ~clk;

    assign txdone = model_en ? mdone : tx_force;

    // Transmitter: done after FRAME cycles of TxInit, low once TxInit drops.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdone <= 1'b0;
            mcnt  <= 0;
        end else if (!mdone) begin
            if (txinit) begin
                if (mcnt == FRAME - 1) begin
                    mdone <= 1'b1;
                    mcnt  <= 0;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
        end else if (!txinit) begin
            mdone <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] val);
        exp_t e;
        e.idx = idx;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic expect_ack(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (ack == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ack_seen"}, 32'(ack != '0), 32'd1);
        if (ack != '0) begin
            chk({tag, "_sb_pending"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, "_ack"}, 32'(ack), 32'(1 << e.idx));
                chk({tag, "_grant"}, 32'(grant), 32'(1 << e.idx));
                chk({tag, "_txdata"}, 32'(txdata), 32'(e.val));
            end
            @(negedge clk);
            chk({tag, "_ack_pulse"}, 32'(ack), 32'd0);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_grant"}, 32'(grant), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int order[$];
        int n;
        int seen;

        rst      = 1'b1;
        req      = '0;
        data     = '0;
        model_en = 1'b1;
        tx_force = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txinit", 32'(txinit), 32'd0);
        chk("rst_txdata", 32'(txdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Simultaneous requests from 0, 1 and 3, held high.
        data[7:0]   = 8'h10;
        data[15:8]  = 8'h21;
        data[31:24] = 8'h43;
        req = 4'b1011;
`ifdef UART_TX_ARB_RR_EN
        order = '{0, 1, 3, 0};
`else
        order = '{0, 0, 0};
`endif
        foreach (order[k]) push(order[k], data[order[k]*8 +: 8]);
        foreach (order[k]) expect_ack("arb");
        req = '0;
        wait_idle("arb");

        // Single request with handshake timing.
        data[23:16] = 8'hA5;
        req = 4'b0100;
        push(2, 8'hA5);
        @(negedge clk);
        chk("single_load_busy", 32'(busy), 32'd1);
        chk("single_load_noack", 32'(ack), 32'd0);
        expect_ack("single");
        req = '0;
        chk("single_txinit_rise", 32'(txinit), 32'd1);
        n = 0;
        while (!txdone && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("single_txdone_seen", 32'(txdone), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("single_txinit_hold", 32'(txinit), 32'd1);
        @(negedge clk);
        chk("single_txinit_fall", 32'(txinit), 32'd0);
        chk("single_release_grant", 32'(grant), 32'b0100);
        chk("single_release_busy", 32'(busy), 32'd1);
        wait_idle("single");

        // Stale done held high in IDLE.
        model_en = 1'b0;
        tx_force = 1'b1;
        repeat (3) @(negedge clk);
        data[7:0] = 8'h3C;
        req = 4'b0001;
        push(0, 8'h3C);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack != '0) seen++;
        end
        chk("stale_no_ack", 32'(seen), 32'd0);
        chk("stale_no_busy", 32'(busy), 32'd0);
        tx_force = 1'b0;
        model_en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == '0 && n < 20);
        chk("stale_ack_delay", 32'(n), 32'd4);
        expect_ack("stale");
        req = '0;
        wait_idle("stale");

        // Back-to-back bytes from requester 1.
        data[15:8] = 8'h11;
        req = 4'b0010;
        push(1, 8'h11);
        push(1, 8'h22);
        push(1, 8'h33);
        expect_ack("b2b0");
        data[15:8] = 8'h22;
        expect_ack("b2b1");
        data[15:8] = 8'h33;
        expect_ack("b2b2");
        req = '0;
        wait_idle("b2b");

        // Reset while in START.
        data[31:24] = 8'h77;
        req = 4'b1000;
        push(3, 8'h77);
        expect_ack("mid");
        req = '0;
        n = 0;
        while (!txinit && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_in_start", 32'(txinit), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_txinit", 32'(txinit), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_txdata", 32'(txdata), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        data[15:8] = 8'h5A;
        req = 4'b0010;
        push(1, 8'h5A);
        expect_ack("post");
        req = '0;
        wait_idle("post");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
